// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional feature macro: WR_ARB_STATS_EN (see fifo_wr_arbiter).
package fifo_arb_pkg;

    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned STATS_W = 16;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // First set bit of valid[n-1:0], searching upward from last+1 and wrapping.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         last,
                                           input int unsigned        n);
        logic [2:0]  win;
        logic        found;
        int unsigned idx;
        logic [2:0]  idx3;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= n; k++) begin
            idx  = (32'(last) + k) % n;
            idx3 = 3'(idx);
            if (!found && valid[idx3]) begin
                win   = idx3;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick_n.sv
// Combinational round-robin priority picker over N requesters.
module rr_pick_n
    import fifo_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_valid,
    input  logic [$clog2(N)-1:0] i_last,
    output logic [$clog2(N)-1:0] o_win,
    output logic                 o_any
);

    localparam int GW = $clog2(N);

    logic [MAX_REQ-1:0] w_valid8;
    logic [2:0]         w_last3;
    logic [2:0]         w_win3;

    // Widen to the helper's fixed width, pick, then narrow back.
    always_comb begin
        w_valid8 = MAX_REQ'(i_valid);
        w_last3  = 3'(i_last);
        w_win3   = rr_pick(w_valid8, w_last3, N);
        o_win    = GW'(w_win3);
        o_any    = |i_valid;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing an async FIFO write port among N_REQ requesters.
// Each grant lasts up to BURST_LEN beats; writes are suppressed while wfull=1.
// Optional macro WR_ARB_STATS_EN adds per-requester beat counters (beat_cnt)
// with a synchronous clear input (stats_clr).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_SIZE = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                         wclk,
    input  logic                         wrst_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*DATA_SIZE-1:0]   req_data,
    output logic [N_REQ-1:0]             req_ready,
    input  logic                         wfull,
    output logic                         winc,
    output logic [DATA_SIZE-1:0]         wdata,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic                         busy
`ifdef WR_ARB_STATS_EN
    ,
    output logic [N_REQ*STATS_W-1:0]     beat_cnt,
    input  logic                         stats_clr
`endif
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(BURST_LEN) + 1;

    arb_state_t       r_state;
    logic [GW-1:0]    r_grant;
    logic [GW-1:0]    r_last;
    logic [CW-1:0]    r_count;

    logic [GW-1:0]    w_win;
    logic             w_any;
    logic             w_beat;
    logic             w_owner_valid;

    rr_pick_n #(.N(N_REQ)) u_pick (
        .i_valid (req_valid),
        .i_last  (r_last),
        .o_win   (w_win),
        .o_any   (w_any)
    );

    // Beat qualification and write-port data mux from the current owner.
    always_comb begin
        w_owner_valid = req_valid[r_grant];
        w_beat        = (r_state == ARB_BURST) && w_owner_valid && !wfull;
        winc          = w_beat;
        req_ready     = w_beat ? (N_REQ'(1) << r_grant) : '0;
        wdata         = req_data[r_grant*DATA_SIZE +: DATA_SIZE];
        grant_id      = r_grant;
        busy          = (r_state == ARB_BURST);
    end

    // Arbitration FSM: grant in IDLE, count beats in BURST, end on length or drop.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_last  <= GW'(N_REQ - 1);
            r_count <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_state <= ARB_BURST;
                        r_grant <= w_win;
                        r_last  <= w_win;
                        r_count <= '0;
                    end
                end
                ARB_BURST: begin
                    if (!w_owner_valid) begin
                        r_state <= ARB_IDLE;
                        r_count <= '0;
                    end else if (w_beat) begin
                        if (r_count == CW'(BURST_LEN - 1)) begin
                            r_state <= ARB_IDLE;
                            r_count <= '0;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

`ifdef WR_ARB_STATS_EN
    logic [STATS_W-1:0] r_stats [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_stats
        // Saturating accepted-beat counter; clear takes priority over a beat.
        always_ff @(posedge wclk or negedge wrst_n) begin
            if (!wrst_n) begin
                r_stats[g] <= '0;
            end else if (stats_clr) begin
                r_stats[g] <= '0;
            end else if (w_beat && (r_grant == GW'(g)) && (r_stats[g] != '1)) begin
                r_stats[g] <= r_stats[g] + 1'b1;
            end
        end
        assign beat_cnt[g*STATS_W +: STATS_W] = r_stats[g];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a transaction-level model predicts
// each accepted beat; a monitor pops and compares whenever winc is seen.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int BL = 4;
    localparam int GW = $clog2(N);

    logic              wclk = 1'b0;
    logic              wrst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*D-1:0]    req_data = '0;
    logic [N-1:0]      req_ready;
    logic              wfull = 1'b0;
    logic              winc;
    logic [D-1:0]      wdata;
    logic [GW-1:0]     grant_id;
    logic              busy;
`ifdef WR_ARB_STATS_EN
    logic [N*16-1:0]   beat_cnt;
    logic              stats_clr = 1'b0;
    int                m_stats [N];
`endif

    fifo_wr_arbiter #(.N_REQ(N), .DATA_SIZE(D), .BURST_LEN(BL)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef WR_ARB_STATS_EN
        ,
        .beat_cnt  (beat_cnt),
        .stats_clr (stats_clr)
`endif
    );

    always #5 wclk = ~wclk;

    typedef struct { int id; logic [D-1:0] data; } beat_t;
    beat_t q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Abstract model: who owns the port, how many beats it has had, who won last.
    int owner = -1;
    int mlast = N - 1;
    int mbeats = 0;
    int prev_beat = -1;
    logic [D-1:0] dat [N];

    task automatic check(input string name, input logic ok, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        owner = -1; mlast = N - 1; mbeats = 0; prev_beat = -1;
`ifdef WR_ARB_STATS_EN
        foreach (m_stats[i]) m_stats[i] = 0;
`endif
    endtask

    // Apply the edge that just happened, using the inputs present before it.
    task automatic model_step();
`ifdef WR_ARB_STATS_EN
        if (stats_clr) begin
            foreach (m_stats[i]) m_stats[i] = 0;
        end else if (prev_beat >= 0 && m_stats[prev_beat] < 65535) begin
            m_stats[prev_beat]++;
        end
`endif
        if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (owner < 0 && req_valid[(mlast + k) % N]) owner = (mlast + k) % N;
            end
            if (owner >= 0) begin mlast = owner; mbeats = 0; end
        end else if (!req_valid[owner]) begin
            owner = -1; mbeats = 0;
        end else if (!wfull) begin
            mbeats++;
            if (mbeats == BL) begin owner = -1; mbeats = 0; end
        end
    endtask

    // mode 0: all valid; 1: only req 0; 2: random churn, rare full;
    // 3: random churn, frequent full; 4: all idle.
    task automatic gen_inputs(input int mode);
        for (int i = 0; i < N; i++) begin
            if (i == prev_beat || !req_valid[i]) dat[i] = D'($urandom);
        end
        case (mode)
            0: begin req_valid = '1; wfull = 1'b0; end
            1: begin req_valid = N'(1); wfull = 1'b0; end
            2, 3: begin
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && i != prev_beat) begin
                        if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                    end else if (!req_valid[i]) begin
                        if ($urandom_range(0, 2) == 0) req_valid[i] = 1'b1;
                    end
                end
                wfull = (mode == 2) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
            end
            default: begin req_valid = '0; wfull = 1'b0; end
        endcase
        for (int i = 0; i < N; i++) req_data[i*D +: D] = dat[i];
`ifdef WR_ARB_STATS_EN
        stats_clr = (mode >= 2) && ($urandom_range(0, 99) == 0);
`endif
    endtask

    task automatic run_cycle(input int mode);
        beat_t b;
        @(posedge wclk);
        model_step();
        #1;
        check("busy", busy == (owner >= 0), longint'(busy), longint'(owner >= 0));
        if (owner >= 0)
            check("grant_id", grant_id == GW'(owner), longint'(grant_id), longint'(owner));
`ifdef WR_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            check("beat_cnt", beat_cnt[i*16 +: 16] == 16'(m_stats[i]),
                  longint'(beat_cnt[i*16 +: 16]), longint'(m_stats[i]));
`endif
        gen_inputs(mode);
        prev_beat = -1;
        if (owner >= 0 && req_valid[owner] && !wfull) begin
            b.id = owner; b.data = dat[owner];
            q.push_back(b);
            prev_beat = owner;
        end
    endtask

    // Monitor: every presented write is matched against the oldest prediction.
    initial begin
        beat_t e;
        forever begin
            @(negedge wclk);
            if (winc) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 1'b0, longint'(grant_id), -1);
                end else begin
                    e = q.pop_front();
                    check("beat", grant_id == GW'(e.id) && wdata == e.data &&
                          req_ready == (N'(1) << e.id),
                          {32'(grant_id), 8'(wdata), 8'(req_ready)},
                          {32'(e.id), 8'(e.data), 8'(N'(1) << e.id)});
                end
            end else if (q.size() != 0) begin
                e = q.pop_front();
                check("missing_beat", 1'b0, 0, longint'(e.id));
            end
        end
    end

    initial begin
        model_reset();
        foreach (dat[i]) dat[i] = '0;
        #1;
        check("reset_winc",  winc == 1'b0, longint'(winc), 0);
        check("reset_busy",  busy == 1'b0, longint'(busy), 0);
        check("reset_ready", req_ready == '0, longint'(req_ready), 0);
        repeat (2) @(posedge wclk);
        #1 wrst_n = 1'b1;

        // Continuous requests from reset: order 0,1,2,3,... with 4-beat bursts.
        for (int c = 0; c < 8 * (BL + 1); c++) run_cycle(0);
        for (int c = 0; c < 30; c++) run_cycle(1);
        for (int c = 0; c < 800; c++) run_cycle(2);
        for (int c = 0; c < 800; c++) run_cycle(3);

        // Async reset in the middle of a burst.
        for (int c = 0; c < 7; c++) run_cycle(0);
        check("pre_reset_busy", busy == 1'b1, longint'(busy), 1);
        @(posedge wclk);
        #2 wrst_n = 1'b0;
        #1;
        check("async_winc",  winc == 1'b0, longint'(winc), 0);
        check("async_busy",  busy == 1'b0, longint'(busy), 0);
        check("async_ready", req_ready == '0, longint'(req_ready), 0);
        model_reset();
        repeat (2) @(posedge wclk);
        #1 wrst_n = 1'b1;
        run_cycle(0);
        check("post_reset_grant", busy == 1'b1 && grant_id == '0,
              longint'(grant_id), 0);
        for (int c = 0; c < 40; c++) run_cycle(0);
        for (int c = 0; c < 400; c++) run_cycle(2);
        for (int c = 0; c < 10; c++) run_cycle(4);

        check("queue_drained", q.size() == 0, longint'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
